dffssr_pipe: RTL and testbench

Parametrised pipeline register built from sync-set/sync-reset flip-flop semantics. It generalises the single-bit set/reset flop to WIDTH bits by DEPTH stages, and adds:
- a clock enable with valid tracking,
- an asynchronous active-low reset,
- a full-length scan chain.

It is used wherever the library needs a multi-cycle, flushable, scan-testable data delay line.

---
 rtl/dffssr_pipe.sv | 59 +++++
 tb/tb_dffssr_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/dffssr_pipe.sv
// rtl/dffssr_pipe.sv - WIDTH x DEPTH set/clear pipeline register with valid tracking and full scan chain
module dffssr_pipe #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             CLK,
    input  logic             RSTB,
    input  logic             SE,
    input  logic             SI,
    input  logic             SSETB,
    input  logic             SRSTB,
    input  logic             EN,
    input  logic             VLD_IN,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             VLD_OUT,
    output logic             SO
);

    localparam int NBITS = WIDTH * DEPTH;

    // Stage k occupies chain[k*WIDTH +: WIDTH], so the scan order n = k*WIDTH+i is the plain bit index.
    logic [NBITS-1:0] chain;
    logic [NBITS-1:0] chain_next;
    logic [NBITS-1:0] scan_next;
    logic [NBITS-1:0] shift_next;
    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] vld_next;

    // Ternary selection keeps known bits when an X control chooses between equal candidates.
    always_comb begin
        scan_next  = (chain << 1) | NBITS'(SI);
        shift_next = (chain << WIDTH) | NBITS'(D);
        chain_next = SE      ? scan_next  :
                     !SSETB  ? '1         :
                     !SRSTB  ? '0         :
                     EN      ? shift_next : chain;
        vld_next   = SE ? vld :
                     EN ? ((vld << 1) | DEPTH'(VLD_IN)) : vld;
    end

    always_ff @(posedge CLK or negedge RSTB) begin
        if (!RSTB) begin
            chain <= {DEPTH{RESET_VAL}};
            vld   <= '0;
        end else begin
            chain <= chain_next;
            vld   <= vld_next;
        end
    end

    assign Q       = chain[NBITS-1 -: WIDTH];
    assign QN      = ~chain[NBITS-1 -: WIDTH];
    assign VLD_OUT = vld[DEPTH-1];
    assign SO      = chain[NBITS-1];

endmodule

// File: tb/tb_dffssr_pipe.sv
// tb/tb_dffssr_pipe.sv - self-checking bench for dffssr_pipe (DEPTH=2 and DEPTH=1 instances)
module tb_dffssr_pipe;

    logic       clk = 1'b0;
    logic       rstb, se, si, ssetb, srstb, en, vld_in;
    logic [7:0] d;
    logic [7:0] q2, qn2, q1, qn1;
    logic       vo2, so2, vo1, so1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dffssr_pipe #(.WIDTH(8), .DEPTH(2), .RESET_VAL(8'hA5)) dut2 (
        .CLK(clk), .RSTB(rstb), .SE(se), .SI(si), .SSETB(ssetb), .SRSTB(srstb),
        .EN(en), .VLD_IN(vld_in), .D(d), .Q(q2), .QN(qn2), .VLD_OUT(vo2), .SO(so2));

    dffssr_pipe #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h0F)) dut1 (
        .CLK(clk), .RSTB(rstb), .SE(se), .SI(si), .SSETB(ssetb), .SRSTB(srstb),
        .EN(en), .VLD_IN(vld_in), .D(d), .Q(q1), .QN(qn1), .VLD_OUT(vo1), .SO(so1));

    // Reference model: instance 0 is DEPTH=2, instance 1 is DEPTH=1.
    logic [7:0] m_s [2][2];
    bit         m_v [2][2];
    int         dep [2] = '{2, 1};
    logic [7:0] rst_val [2] = '{8'hA5, 8'h0F};

    task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int x = 0; x < 2; x++)
            for (int k = 0; k < 2; k++) begin
                m_s[x][k] = rst_val[x];
                m_v[x][k] = 1'b0;
            end
    endtask

    task automatic model_edge(input int x);
        bit bits[$];
        int dp = dep[x];
        if (se) begin
            for (int k = 0; k < dp; k++)
                for (int i = 0; i < 8; i++) bits.push_back(m_s[x][k][i]);
            bits.push_front(si);
            void'(bits.pop_back());
            for (int k = 0; k < dp; k++)
                for (int i = 0; i < 8; i++) m_s[x][k][i] = bits[k*8+i];
        end else begin
            if (en) begin
                for (int k = dp - 1; k > 0; k--) m_v[x][k] = m_v[x][k-1];
                m_v[x][0] = vld_in;
            end
            if (!ssetb)
                for (int k = 0; k < dp; k++) m_s[x][k] = 8'hFF;
            else if (!srstb)
                for (int k = 0; k < dp; k++) m_s[x][k] = 8'h00;
            else if (en) begin
                for (int k = dp - 1; k > 0; k--) m_s[x][k] = m_s[x][k-1];
                m_s[x][0] = d;
            end
        end
    endtask

    task automatic check_model();
        cmp("q_d2",   q2,         m_s[0][1]);
        cmp("qn_d2",  qn2,        ~m_s[0][1]);
        cmp("vld_d2", {7'd0,vo2}, {7'd0,m_v[0][1]});
        cmp("so_d2",  {7'd0,so2}, {7'd0,m_s[0][1][7]});
        cmp("q_d1",   q1,         m_s[1][0]);
        cmp("qn_d1",  qn1,        ~m_s[1][0]);
        cmp("vld_d1", {7'd0,vo1}, {7'd0,m_v[1][0]});
        cmp("so_d1",  {7'd0,so1}, {7'd0,m_s[1][0][7]});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstb) begin
            model_edge(0);
            model_edge(1);
        end
        #1;
        check_model();
    endtask

    // Called just after a tick: pulls RSTB low mid-cycle, checks without a clock edge, releases at negedge.
    task automatic async_reset();
        #2 rstb = 1'b0;
        model_reset();
        #1;
        check_model();
        cmp("rst_q_d2",   q2,         8'hA5);
        cmp("rst_qn_d2",  qn2,        8'h5A);
        cmp("rst_vld_d2", {7'd0,vo2}, 8'h00);
        cmp("rst_so_d2",  {7'd0,so2}, 8'h01);
        cmp("rst_q_d1",   q1,         8'h0F);
        @(negedge clk) rstb = 1'b1;
    endtask

    typedef struct {
        logic       ssetb, srstb, en, vld;
        logic [7:0] d;
        logic [7:0] exp_q;
        logic       exp_v;
    } vec_t;

    vec_t       tbl [10];
    logic [7:0] seen[$];
    logic [15:0] pre, pat;
    logic [7:0] b81;

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h3C, 8'hA5, 1'b0};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 8'h3C, 1'b1};
        tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h77, 8'h3C, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h22, 8'h11, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 8'hFF, 1'b1};
        tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h44, 8'h00, 1'b0};
        tbl[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h55, 8'h00, 1'b0};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h5A, 8'h00, 1'b1};
        tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'hC3, 8'h5A, 1'b1};
        tbl[9] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'hC3, 1'b0};

        rstb = 1'b1; se = 1'b0; si = 1'b0; ssetb = 1'b1; srstb = 1'b1;
        en = 1'b0; vld_in = 1'b0; d = 8'h00;
        async_reset();

        // Reset-then-load, set dominance, clear, stall of valid flags
        for (int r = 0; r < 10; r++) begin
            ssetb = tbl[r].ssetb; srstb = tbl[r].srstb; en = tbl[r].en;
            vld_in = tbl[r].vld; d = tbl[r].d;
            tick();
            cmp($sformatf("tbl%0d_q", r),   q2,         tbl[r].exp_q);
            cmp($sformatf("tbl%0d_vld", r), {7'd0,vo2}, {7'd0,tbl[r].exp_v});
        end
        ssetb = 1'b1; srstb = 1'b1;

        // Stall: 1,2 then three EN=0 cycles, then 3, then flush
        en = 1'b1; vld_in = 1'b1; d = 8'd1; tick(); if (vo2) seen.push_back(q2);
        d = 8'd2; tick(); if (vo2) seen.push_back(q2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom); vld_in = 1'($urandom);
            tick();
            cmp("stall_q", q2, 8'd1);
            cmp("stall_vld", {7'd0,vo2}, 8'd1);
        end
        en = 1'b1; vld_in = 1'b1; d = 8'd3; tick(); if (vo2) seen.push_back(q2);
        vld_in = 1'b0; d = 8'hEE; tick(); if (vo2) seen.push_back(q2);
        tick(); if (vo2) seen.push_back(q2);
        cmp("stall_count", 8'(seen.size()), 8'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            cmp($sformatf("stall_seq%0d", i), seen[i], 8'(i + 1));

        // Scan 16'hBEEF in (bit 15 first) over contents 11/22 with SSETB held low
        vld_in = 1'b1; d = 8'h11; tick(); d = 8'h22; tick();
        pre = 16'h1122; pat = 16'hBEEF;
        se = 1'b1; ssetb = 1'b0; en = 1'b1;
        for (int j = 0; j < 16; j++) begin
            cmp($sformatf("scan_so%0d", j), {7'd0,so2}, {7'd0,pre[15-j]});
            si = pat[15-j];
            tick();
        end
        cmp("scan_s1", q2, 8'hBE);
        se = 1'b0; ssetb = 1'b1; d = 8'h00;
        tick();
        cmp("scan_s0", q2, 8'hEF);

        // Async reset after 5 scan edges
        se = 1'b1;
        for (int j = 0; j < 5; j++) begin si = 1'($urandom); tick(); end
        async_reset();
        se = 1'b0;

        // DEPTH=1 corner: load then scan out the same bits
        en = 1'b1; vld_in = 1'b1; d = 8'h81; tick();
        cmp("d1_q", q1, 8'h81);
        cmp("d1_vld", {7'd0,vo1}, 8'd1);
        b81 = 8'h81;
        se = 1'b1; si = 1'b0;
        for (int j = 0; j < 8; j++) begin
            cmp($sformatf("d1_so%0d", j), {7'd0,so1}, {7'd0,b81[7-j]});
            tick();
        end
        cmp("d1_scan_empty", q1, 8'h00);
        se = 1'b0;

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            se     = ($urandom % 6) == 0;
            si     = 1'($urandom);
            ssetb  = ($urandom % 10) != 0;
            srstb  = ($urandom % 8) != 0;
            en     = ($urandom % 4) != 0;
            vld_in = 1'($urandom);
            d      = 8'($urandom);
            tick();
            if (($urandom % 50) == 0) async_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
